// File: rtl/id_stage.sv
// Instruction-decode stage with integrated ID/EX register, register file and load-use stall.
// Optional macro ID_WB_BYPASS_EN: WB write-through to same-cycle operand reads.
module id_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [DATA_W-1:0]     if_pc,
    output logic                  id_ready,
    input  logic                  ex_ready,
    input  logic                  flush,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_branch_z,
    output logic                  ex_branch_n,
    output logic                  ex_jump,
    output logic                  ex_jump_mem,
    output logic                  ex_pc_src,
    output logic [2:0]            ex_alu_op,
    output logic                  ex_illegal
);

    typedef struct packed {
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch_z;
        logic       branch_n;
        logic       jump;
        logic       jump_mem;
        logic       pc_src;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_NEG    = 3'b010;
    localparam logic [2:0] ALU_PASS_A = 3'b011;

    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [IMM_W-1:0]      imm;
    ctrl_t                 dec;
    ctrl_t                 ex_ctrl;
    logic                  uses_rs;
    logic                  uses_rt;
    logic                  haz;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     regs [2**REG_ADDR_W];

    assign opcode = if_instr[31:28];
    assign rd     = if_instr[22 +: REG_ADDR_W];
    assign rs     = if_instr[16 +: REG_ADDR_W];
    assign rt     = if_instr[10 +: REG_ADDR_W];
    assign imm    = if_instr[IMM_W-1:0];

    always_comb begin
        dec     = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            4'b0000: ;
            4'b1111: begin dec.reg_write = 1'b1; dec.pc_src = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD; end
            4'b1110: begin
                dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = ALU_PASS_A; uses_rs = 1'b1;
            end
            4'b0011: begin dec.mem_write = 1'b1; dec.alu_op = ALU_PASS_A; uses_rs = 1'b1; uses_rt = 1'b1; end
            4'b0100: begin dec.reg_write = 1'b1; dec.alu_op = ALU_ADD; uses_rs = 1'b1; uses_rt = 1'b1; end
            4'b0111: begin dec.reg_write = 1'b1; dec.alu_op = ALU_SUB; uses_rs = 1'b1; uses_rt = 1'b1; end
            4'b0101: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD; uses_rs = 1'b1; end
            4'b0110: begin dec.reg_write = 1'b1; dec.alu_op = ALU_NEG; uses_rs = 1'b1; end
            4'b1000: begin dec.jump = 1'b1; uses_rs = 1'b1; end
            4'b1001: begin dec.branch_z = 1'b1; uses_rs = 1'b1; end
            4'b1011: begin dec.branch_n = 1'b1; uses_rs = 1'b1; end
            4'b1010: begin dec.jump_mem = 1'b1; dec.mem_read = 1'b1; uses_rs = 1'b1; end
            default: dec.illegal = 1'b1;
        endcase
    end

`ifdef ID_WB_BYPASS_EN
    assign rs_data = (wb_we && wb_addr == rs) ? wb_data : regs[rs];
    assign rt_data = (wb_we && wb_addr == rt) ? wb_data : regs[rt];
`else
    assign rs_data = regs[rs];
    assign rt_data = regs[rt];
`endif

    // Only a load in EX can still be waiting on memory, so only it forces a stall.
    assign haz = if_valid & ex_valid & ex_ctrl.mem_read &
                 ((uses_rs & (ex_rd == rs)) | (uses_rt & (ex_rd == rt)));

    assign id_ready = rst_n & ex_ready & ~haz & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_pc      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (ex_ready) begin
            if (haz) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
            end else begin
                ex_valid   <= if_valid;
                ex_ctrl    <= if_valid ? dec : '0;
                ex_pc      <= if_pc;
                ex_rs_data <= rs_data;
                ex_rt_data <= rt_data;
                ex_imm     <= {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
                ex_rd      <= rd;
            end
        end
    end

    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_branch_z   = ex_ctrl.branch_z;
    assign ex_branch_n   = ex_ctrl.branch_n;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_jump_mem   = ex_ctrl.jump_mem;
    assign ex_pc_src     = ex_ctrl.pc_src;
    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_illegal    = ex_ctrl.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode stage with an integrated ID/EX pipeline register for the SCU pipelined core. It decodes the 4-bit opcode into EX/MEM/WB control, reads two operands from an internal register file written by WB, sign-extends the immediate, and detects load-use hazards, inserting one bubble per hazard. Upstream is the IF/ID register; downstream is the EX stage. Branch resolution lives in EX; EX requests squashes through `flush`.

## Interface
- `DATA_W`, 32: datapath and PC width.
- `REG_ADDR_W`, 6: register index width; the file holds 2^REG_ADDR_W registers.
- `IMM_W`, 16: immediate field width, taken from instr[IMM_W-1:0].
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `if_valid` in 1: IF/ID holds a valid instruction.
- `if_instr` in 32: instruction word. Fields: opcode [31:28], rd [27:22], rs [21:16], rt [15:10].
- `if_pc` in DATA_W: PC of `if_instr`.
- `id_ready` out 1: ID accepts the instruction this cycle.
- `ex_ready` in 1: EX accepts the ID/EX contents this cycle.
- `flush` in 1: squash the ID/EX contents and the current ID instruction.
- `wb_we`, `wb_addr` [REG_ADDR_W], `wb_data` [DATA_W] in: register write port.
- `ex_valid` out 1; `ex_pc`, `ex_rs_data`, `ex_rt_data`, `ex_imm` out DATA_W; `ex_rd` out REG_ADDR_W.
- `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_reg_write`, `ex_branch_z`, `ex_branch_n`, `ex_jump`, `ex_jump_mem`, `ex_pc_src` out 1 each; `ex_alu_op` out 3.
- `ex_illegal` out 1: the registered instruction had an undefined opcode.

## Operation
- Opcode map, decoded as opcode → asserted controls:
  - 0000 NOP: none.
  - 1111 SVPC: reg_write, pc_src, alu_src, alu_op=ADD.
  - 1110 LD: mem_read, mem_to_reg, reg_write, alu_op=PASS_A; uses rs.
  - 0011 ST: mem_write, alu_op=PASS_A; uses rs and rt.
  - 0100 ADD and 0111 SUB: reg_write, alu_op=ADD or SUB; uses rs and rt.
  - 0101 INC: reg_write, alu_src, alu_op=ADD; uses rs.
  - 0110 NEG: reg_write, alu_op=NEG; uses rs.
  - 1000 J: jump; uses rs.
  - 1001 BRZ and 1011 BRN: branch_z or branch_n; uses rs.
  - 1010 JM: jump_mem, mem_read; uses rs.
  - Any other opcode decodes as NOP with illegal=1.
- `alu_op` encoding: ADD=000, SUB=001, NEG=010, PASS_A=011.
- Immediate: instr[IMM_W-1:0] sign-extended to DATA_W.
- Register file: 2^REG_ADDR_W × DATA_W. Written on the rising edge when `wb_we`=1. Read combinationally at rs and rt.
- Load-use hazard, `haz` = `if_valid` & `ex_valid` & `ex_mem_read` & ((uses_rs & `ex_rd`==rs) | (uses_rt & `ex_rd`==rt)).
- `id_ready` = `ex_ready` & ~`haz` & ~`flush`.
- ID/EX update priority, highest first:
  1. `flush`: `ex_valid`←0.
  2. ~`ex_ready`: all ex_* hold.
  3. `haz`: bubble, `ex_valid`←0 with all control outputs 0.
  4. Otherwise load the decoded instruction; `ex_valid`←`if_valid`.
- When `ex_valid`=0, every control output is 0. Data outputs are don't-care.

## Timing
- Decode-to-output latency is one cycle: the instruction accepted at edge N appears on ex_* after edge N.
- Reset (`rst_n`=0 at an edge): all ex_* outputs ← 0, all registers ← 0.
- `id_ready` is 0 while `rst_n`=0.
- Reset in the middle of a hazard or backpressure drops the pending instruction.
- A hazard stalls for exactly one cycle. On the next cycle the bubble clears `ex_valid`, so `haz` deasserts.
- `flush` and `haz` in the same cycle: flush wins, and the ID instruction is not accepted.
- `ex_ready`=0 and `flush`=1 in the same cycle: flush wins.
- WB write and an ID read of the same register in the same cycle: the result depends on `ID_WB_BYPASS_EN`.

## Configuration
- `ID_WB_BYPASS_EN` defined: write-through bypass. When `wb_we` and `wb_addr` equals rs or rt, the read returns `wb_data` in that cycle.
- `ID_WB_BYPASS_EN` undefined: the read returns the pre-write value. The hazard logic does not cover this case; software must space the dependent instructions.

## Test plan
- Reset, then ADD r3,r1,r2 with WB preloads r1=5, r2=7 → next cycle `ex_valid`=1, `ex_rs_data`=5, `ex_rt_data`=7, `ex_alu_op`=000, `ex_reg_write`=1, `ex_rd`=3.
- LD r4,r1 followed by ADD r5,r4,r2 → `id_ready`=0 for one cycle, the bubble has `ex_valid`=0, then ADD issues.
- `ex_ready`=0 for 3 cycles holding SUB → all ex_* stable, `id_ready`=0, SUB is presented once.
- `flush`=1 while a hazard is active → next cycle `ex_valid`=0; the ID instruction must be re-presented.
- `wb_we` r6=0xDEAD in the same cycle as a read of r6 → `ex_rs_data`=0xDEAD with bypass, the old value without.
- INC with imm 0xFFFF → `ex_imm`=0xFFFFFFFF. Opcode 0001 → `ex_illegal`=1, all controls 0.
